// File: rtl/game_screen_compositor.sv
// Screen compositor: ROM address generation, pipeline alignment and layer merge
// of background, animation and a mode-selected overlay window into 12-bit RGB.
module game_screen_compositor #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int BG_SHIFT    = 1,
    parameter int ROM_LAT     = 1,
    parameter int OVL0_X0     = 95,
    parameter int OVL0_Y0     = 85,
    parameter int OVL0_W      = 450,
    parameter int OVL0_H      = 280,
    parameter int OVL1_X0     = 130,
    parameter int OVL1_Y0     = 120,
    parameter int OVL1_W      = 380,
    parameter int OVL1_H      = 180,
    parameter int FADE_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  mode_in,
    input  logic        frame_start,
    input  logic [10:0] xpos,
    input  logic [10:0] ypos,
    input  logic        blink_tick,
    output logic [16:0] bg_addr,
    input  logic [7:0]  bg_data,
    output logic [16:0] ovl_addr,
    input  logic [2:0]  ovl_data,
    input  logic [11:0] show_data,
    output logic [2:0]  mode_active,
    output logic        mode_busy,
    output logic [11:0] vga_data,
    output logic        vga_valid
);

    localparam logic [2:0]  MODE_TITLE = 3'd0;
    localparam logic [2:0]  MODE_OVER  = 3'd3;
    localparam logic [16:0] H_LIM      = 17'(H_RES);
    localparam logic [16:0] V_LIM      = 17'(V_RES);
    localparam logic [16:0] BG_PITCH   = 17'(H_RES >> BG_SHIFT);
    localparam logic [16:0] O0_X0 = 17'(OVL0_X0), O0_Y0 = 17'(OVL0_Y0);
    localparam logic [16:0] O0_W  = 17'(OVL0_W),  O0_H  = 17'(OVL0_H);
    localparam logic [16:0] O1_X0 = 17'(OVL1_X0), O1_Y0 = 17'(OVL1_Y0);
    localparam logic [16:0] O1_W  = 17'(OVL1_W),  O1_H  = 17'(OVL1_H);
    localparam logic [15:0] FADE_TGT   = 16'(FADE_FRAMES);
    localparam bit          FADE_OFF   = (FADE_FRAMES == 0);

    logic [16:0]  bgAddr_q, bgAddr_d, ovlAddr_q, ovlAddr_d;
    logic [ROM_LAT:0] visSr_q, winSr_q;
    logic [2:0]   modeActive_q, modeActive_d;
    logic         modeBusy_q, modeBusy_d;
    logic [2:0]   level_q, level_d;
    logic [15:0]  frameCnt_q, frameCnt_d;
    logic         blinkVis_q, blinkVis_d, blinkPend_q, blinkPend_d;
    logic [11:0]  vga_q, vga_d;
    logic         valid_q;

    logic [16:0]  xExt, yExt, winX0, winY0, winW, winH;
    logic         visA, winA, overlayMode;
    logic [11:0]  bgExp, ovlPix;
    logic [3:0]   mask;
    logic [2:0]   effLevel;

    assign xExt = {6'd0, xpos};
    assign yExt = {6'd0, ypos};
    assign visA = (xExt >= 17'd1) && (xExt <= H_LIM) && (yExt >= 17'd1) && (yExt <= V_LIM);

    // Stage A: pick the active window, then form both ROM addresses.
    always_comb begin
        overlayMode = (modeActive_q == MODE_TITLE) || (modeActive_q == MODE_OVER);
        winX0 = (modeActive_q == MODE_OVER) ? O1_X0 : O0_X0;
        winY0 = (modeActive_q == MODE_OVER) ? O1_Y0 : O0_Y0;
        winW  = (modeActive_q == MODE_OVER) ? O1_W  : O0_W;
        winH  = (modeActive_q == MODE_OVER) ? O1_H  : O0_H;
        winA  = overlayMode && visA &&
                (xExt > winX0) && (xExt <= winX0 + winW) &&
                (yExt > winY0) && (yExt <= winY0 + winH);
        bgAddr_d  = bgAddr_q;
        ovlAddr_d = ovlAddr_q;
        if (visA)
            bgAddr_d = ((xExt - 17'd1) >> BG_SHIFT) + BG_PITCH * ((yExt - 17'd1) >> BG_SHIFT);
        if (winA)
            ovlAddr_d = (xExt - winX0 - 17'd1) + winW * (yExt - winY0 - 17'd1);
    end

    // A mode change resets fade and blink; otherwise the frame advances both.
    always_comb begin
        modeActive_d = modeActive_q;
        level_d      = level_q;
        frameCnt_d   = frameCnt_q;
        blinkVis_d   = blinkVis_q;
        blinkPend_d  = blinkPend_q;
        if (frame_start) begin
            modeActive_d = mode_in;
            if (mode_in != modeActive_q) begin
                level_d     = 3'd0;
                frameCnt_d  = 16'd0;
                blinkVis_d  = 1'b1;
                blinkPend_d = 1'b0;
            end else begin
                if (FADE_OFF) begin
                    level_d = 3'd4;
                end else if (frameCnt_q + 16'd1 == FADE_TGT) begin
                    frameCnt_d = 16'd0;
                    level_d    = (level_q >= 3'd4) ? 3'd4 : level_q + 3'd1;
                end else begin
                    frameCnt_d = frameCnt_q + 16'd1;
                end
                if (modeActive_q == MODE_OVER) begin
                    if (blinkPend_q || blink_tick) begin
                        blinkVis_d  = ~blinkVis_q;
                        blinkPend_d = 1'b0;
                    end
                end else begin
                    blinkVis_d  = 1'b1;
                    blinkPend_d = 1'b0;
                end
            end
        end else if (modeActive_q == MODE_OVER) begin
            if (blink_tick)
                blinkPend_d = 1'b1;
        end else begin
            blinkVis_d  = 1'b1;
            blinkPend_d = 1'b0;
        end
        modeBusy_d = (mode_in != modeActive_d);
    end

    assign effLevel = FADE_OFF ? 3'd4 : level_q;
    assign bgExp = {bg_data[7], bg_data[6], {2{bg_data[5]}}, bg_data[4], bg_data[3],
                    {2{bg_data[2]}}, {2{bg_data[1]}}, {2{bg_data[0]}}};

    always_comb begin
        case (effLevel)
            3'd0:    mask = 4'b0000;
            3'd1:    mask = 4'b0001;
            3'd2:    mask = 4'b0011;
            3'd3:    mask = 4'b0111;
            default: mask = 4'b1111;
        endcase
        ovlPix = 12'd0;
        if (winSr_q[ROM_LAT] && blinkVis_q)
            ovlPix = {{4{ovl_data[2]}} & mask, {4{ovl_data[1]}} & mask, {4{ovl_data[0]}} & mask};
        case (modeActive_q)
            3'd0:    vga_d = bgExp | show_data | ovlPix;
            3'd1,
            3'd2:    vga_d = bgExp;
            3'd3:    vga_d = bgExp | ovlPix;
            default: vga_d = 12'd0;
        endcase
        if (!visSr_q[ROM_LAT])
            vga_d = 12'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bgAddr_q     <= '0;
            ovlAddr_q    <= '0;
            visSr_q      <= '0;
            winSr_q      <= '0;
            modeActive_q <= '0;
            modeBusy_q   <= 1'b0;
            level_q      <= '0;
            frameCnt_q   <= '0;
            blinkVis_q   <= 1'b1;
            blinkPend_q  <= 1'b0;
            vga_q        <= '0;
            valid_q      <= 1'b0;
        end else begin
            bgAddr_q     <= bgAddr_d;
            ovlAddr_q    <= ovlAddr_d;
            visSr_q      <= {visSr_q[ROM_LAT-1:0], visA};
            winSr_q      <= {winSr_q[ROM_LAT-1:0], winA};
            modeActive_q <= modeActive_d;
            modeBusy_q   <= modeBusy_d;
            level_q      <= level_d;
            frameCnt_q   <= frameCnt_d;
            blinkVis_q   <= blinkVis_d;
            blinkPend_q  <= blinkPend_d;
            vga_q        <= vga_d;
            valid_q      <= visSr_q[ROM_LAT];
        end
    end

    assign bg_addr     = bgAddr_q;
    assign ovl_addr    = ovlAddr_q;
    assign mode_active = modeActive_q;
    assign mode_busy   = modeBusy_q;
    assign vga_data    = vga_q;
    assign vga_valid   = valid_q;

endmodule

// File: tb/tb_game_screen_compositor.sv
// Directed bench for game_screen_compositor: table of single-pixel vectors plus
// sequences for reset, mode commit, fade, blink and mid-frame reset.
module tb_game_screen_compositor;

    logic        clk, rst_n, frame_start, blink_tick, mode_busy, vga_valid;
    logic [2:0]  mode_in, ovl_data, mode_active;
    logic [10:0] xpos, ypos;
    logic [16:0] bg_addr, ovl_addr;
    logic [7:0]  bg_data;
    logic [11:0] show_data, vga_data;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic [2:0]  mode;
        logic [10:0] x;
        logic [10:0] y;
        logic [7:0]  bg;
        logic [2:0]  ovl;
        logic [11:0] show;
        logic [16:0] expBg;
        logic [16:0] expOvl;
        logic [11:0] expVga;
        logic        expValid;
    } vec_t;

    vec_t vecs[11];

    game_screen_compositor #(.FADE_FRAMES(2)) dut (
        .clk(clk), .rst_n(rst_n), .mode_in(mode_in), .frame_start(frame_start),
        .xpos(xpos), .ypos(ypos), .blink_tick(blink_tick),
        .bg_addr(bg_addr), .bg_data(bg_data), .ovl_addr(ovl_addr), .ovl_data(ovl_data),
        .show_data(show_data), .mode_active(mode_active), .mode_busy(mode_busy),
        .vga_data(vga_data), .vga_valid(vga_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [10:0] x, input logic [10:0] y);
        xpos = x;
        ypos = y;
        tick();
        xpos = 11'd0;
        ypos = 11'd0;
    endtask

    task automatic framePulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic measurePixel(input logic [10:0] x, input logic [10:0] y, output logic [11:0] v);
        applyStimulus(x, y);
        tick();
        tick();
        v = vga_data;
    endtask

    initial begin
        logic [2:0]  curMode;
        logic [11:0] pix;
        logic [11:0] fadeExp[6];

        vecs[0]  = '{3'd1, 11'd3,   11'd5,   8'hFF, 3'd0, 12'h000, 17'd641,   17'd0,      12'hFFF, 1'b1};
        vecs[1]  = '{3'd1, 11'd641, 11'd5,   8'hFF, 3'd0, 12'h000, 17'd641,   17'd0,      12'h000, 1'b0};
        vecs[2]  = '{3'd1, 11'd1,   11'd1,   8'h01, 3'd0, 12'h000, 17'd0,     17'd0,      12'h003, 1'b1};
        vecs[3]  = '{3'd2, 11'd640, 11'd480, 8'h80, 3'd0, 12'h000, 17'd76799, 17'd0,      12'h800, 1'b1};
        vecs[4]  = '{3'd2, 11'd0,   11'd100, 8'h80, 3'd0, 12'h000, 17'd76799, 17'd0,      12'h000, 1'b0};
        vecs[5]  = '{3'd4, 11'd10,  11'd10,  8'hFF, 3'd0, 12'h000, 17'd1284,  17'd0,      12'h000, 1'b1};
        vecs[6]  = '{3'd0, 11'd10,  11'd10,  8'h22, 3'd7, 12'h400, 17'd1284,  17'd0,      12'h70C, 1'b1};
        vecs[7]  = '{3'd0, 11'd96,  11'd86,  8'h10, 3'd7, 12'h000, 17'd13487, 17'd0,      12'h080, 1'b1};
        vecs[8]  = '{3'd0, 11'd545, 11'd365, 8'h00, 3'd7, 12'h000, 17'd58512, 17'd125999, 12'h000, 1'b1};
        vecs[9]  = '{3'd0, 11'd95,  11'd85,  8'h40, 3'd7, 12'h000, 17'd13487, 17'd125999, 12'h400, 1'b1};
        vecs[10] = '{3'd0, 11'd546, 11'd200, 8'h08, 3'd7, 12'h000, 17'd31952, 17'd125999, 12'h040, 1'b1};
        fadeExp = '{12'h000, 12'h111, 12'h333, 12'h777, 12'hFFF, 12'hFFF};

        rst_n = 1'b0; mode_in = 3'd1; frame_start = 1'b0; blink_tick = 1'b0;
        xpos = 11'd10; ypos = 11'd10; bg_data = 8'hFF; ovl_data = 3'd0; show_data = 12'd0;

        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rst_vga", 32'(vga_data), 0);
            checkOutput("rst_valid", 32'(vga_valid), 0);
            checkOutput("rst_mode", 32'(mode_active), 0);
            checkOutput("rst_bgaddr", 32'(bg_addr), 0);
            checkOutput("rst_busy", 32'(mode_busy), 0);
        end
        rst_n = 1'b1;
        tick();
        checkOutput("post_rst_vga", 32'(vga_data), 0);
        checkOutput("post_rst_valid", 32'(vga_valid), 0);
        checkOutput("post_rst_mode", 32'(mode_active), 0);
        xpos = 11'd0; ypos = 11'd0;
        tick(); tick(); tick();
        curMode = 3'd0;

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].mode != curMode) begin
                mode_in = vecs[i].mode;
                framePulse();
                curMode = vecs[i].mode;
            end
            bg_data   = vecs[i].bg;
            ovl_data  = vecs[i].ovl;
            show_data = vecs[i].show;
            applyStimulus(vecs[i].x, vecs[i].y);
            checkOutput($sformatf("vec%0d_bgaddr", i), 32'(bg_addr), 32'(vecs[i].expBg));
            checkOutput($sformatf("vec%0d_ovladdr", i), 32'(ovl_addr), 32'(vecs[i].expOvl));
            tick();
            tick();
            checkOutput($sformatf("vec%0d_vga", i), 32'(vga_data), 32'(vecs[i].expVga));
            checkOutput($sformatf("vec%0d_valid", i), 32'(vga_valid), 32'(vecs[i].expValid));
        end

        // Mode commit waits for the frame boundary
        mode_in = 3'd1;
        framePulse();
        checkOutput("commit_mode1", 32'(mode_active), 1);
        checkOutput("commit_busy0", 32'(mode_busy), 0);
        mode_in = 3'd3;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("pending_busy", 32'(mode_busy), 1);
            checkOutput("pending_mode", 32'(mode_active), 1);
        end
        framePulse();
        checkOutput("commit_mode3", 32'(mode_active), 3);
        checkOutput("commit_busy_clr", 32'(mode_busy), 0);

        // Fade ramp, two frames per level
        bg_data = 8'h00; ovl_data = 3'd7; show_data = 12'h000;
        for (int k = 0; k < 6; k++) begin
            measurePixel(11'd131, 11'd121, pix);
            checkOutput($sformatf("fade_step%0d", k), 32'(pix), 32'(fadeExp[k]));
            checkOutput($sformatf("fade_ovladdr%0d", k), 32'(ovl_addr), 0);
            framePulse();
            framePulse();
        end

        // Blink: pending tick, then tick coincident with frame_start
        bg_data = 8'h01;
        blink_tick = 1'b1; tick(); blink_tick = 1'b0;
        tick();
        measurePixel(11'd131, 11'd121, pix);
        checkOutput("blink_before_frame", 32'(pix), 32'h FFF);
        framePulse();
        measurePixel(11'd131, 11'd121, pix);
        checkOutput("blink_hidden", 32'(pix), 32'h003);
        blink_tick = 1'b1; frame_start = 1'b1;
        tick();
        blink_tick = 1'b0; frame_start = 1'b0;
        measurePixel(11'd131, 11'd121, pix);
        checkOutput("blink_shown", 32'(pix), 32'hFFF);
        framePulse();
        measurePixel(11'd131, 11'd121, pix);
        checkOutput("blink_hold", 32'(pix), 32'hFFF);

        // Mode 1 ignores blink ticks and never shows the overlay
        mode_in = 3'd1;
        framePulse();
        blink_tick = 1'b1; tick(); blink_tick = 1'b0;
        framePulse();
        measurePixel(11'd131, 11'd121, pix);
        checkOutput("mode1_bg_only", 32'(pix), 32'h003);
        checkOutput("mode1_active", 32'(mode_active), 1);

        // Reset in the middle of a pixel's flight through the pipeline
        bg_data = 8'hFF;
        applyStimulus(11'd3, 11'd5);
        rst_n = 1'b0;
        tick();
        checkOutput("midrst_vga", 32'(vga_data), 0);
        checkOutput("midrst_valid", 32'(vga_valid), 0);
        checkOutput("midrst_mode", 32'(mode_active), 0);
        checkOutput("midrst_bgaddr", 32'(bg_addr), 0);
        rst_n = 1'b1;
        tick();
        tick();
        checkOutput("midrst_flushed", 32'(vga_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
